cflog_reader: RTL and testbench

CFLOG_READER -- requirements
Module: cflog_reader

---
 rtl/cflog_reader_pkg.sv | 28 ++
 rtl/cflog_reader.sv | 118 +++++++++++
 tb/tb_cflog_reader.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cflog_reader_pkg.sv
// Shared types for the control-flow log reader: capacity default, FSM states
// and the header word that precedes every drain.
package cflog_reader_pkg;

    localparam int unsigned WORD_W = 16;
    localparam logic [WORD_W-1:0] LOG_SIZE_DEFAULT = 16'h0100;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD,
        CAP,
        SEND,
        DONE
    } state_t;

    // Header word: number of log entries that follow in this drain.
    typedef struct packed {
        logic [WORD_W-1:0] count;
    } hdr_word_t;

    function automatic hdr_word_t make_hdr(input logic [WORD_W-1:0] cnt);
        hdr_word_t h;
        h.count = cnt;
        return h;
    endfunction

endpackage

// File: rtl/cflog_reader.sv
// Drains the control-flow log: emits a count header, then each entry read
// from log memory, then asks the writer to clear its pointer.
module cflog_reader
    import cflog_reader_pkg::*;
#(
    parameter logic [WORD_W-1:0] LOG_SIZE = LOG_SIZE_DEFAULT,
    parameter logic [WORD_W-1:0] LOG_BASE = 16'h0000
) (
    input  logic              clk,
    input  logic              puc_n,
    input  logic              flush,
    input  logic [WORD_W-1:0] cflow_log_ptr,
    output logic              mem_rd_en,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rd_data,
    output logic              tx_valid,
    output logic [WORD_W-1:0] tx_data,
    output logic              tx_last,
    input  logic              tx_ready,
    output logic              busy,
    output logic              log_clr
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] data_d;
    logic [WORD_W-1:0] addr_d;
    logic              last_d;
    logic              valid_d;
    logic              rd_en_d;
    logic              busy_d;
    logic              clr_d;
    logic [WORD_W-1:0] clamp;

    assign clamp = (cflow_log_ptr > LOG_SIZE) ? LOG_SIZE : cflow_log_ptr;

    // Next state plus next values of every registered output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = tx_data;
        last_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    cnt_d   = clamp;
                    idx_d   = '0;
                    data_d  = make_hdr(clamp);
                    last_d  = (clamp == '0);
                    state_d = HDR;
                end
            end
            HDR: begin
                if (tx_ready) begin
                    state_d = (cnt_q == '0) ? DONE : RD;
                end else begin
                    last_d = tx_last;
                end
            end
            RD: begin
                state_d = CAP;
            end
            CAP: begin
                data_d  = mem_rd_data;
                last_d  = (idx_q == WORD_W'(cnt_q - WORD_W'(1)));
                state_d = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    idx_d   = WORD_W'(idx_q + WORD_W'(1));
                    state_d = tx_last ? DONE : RD;
                end else begin
                    last_d = tx_last;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == HDR) || (state_d == SEND);
        rd_en_d = (state_d == RD);
        busy_d  = (state_d != IDLE);
        clr_d   = (state_d == DONE);
        addr_d  = WORD_W'(LOG_BASE + idx_d);
    end

    always_ff @(posedge clk or negedge puc_n) begin
        if (!puc_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            tx_data   <= '0;
            tx_last   <= 1'b0;
            tx_valid  <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            log_clr   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            tx_data   <= data_d;
            tx_last   <= last_d;
            tx_valid  <= valid_d;
            mem_rd_en <= rd_en_d;
            mem_addr  <= addr_d;
            busy      <= busy_d;
            log_clr   <= clr_d;
        end
    end

endmodule

// File: tb/tb_cflog_reader.sv
// Scoreboard bench for cflog_reader: expected words and read addresses are
// queued at flush time and retired by a negedge monitor.
module tb_cflog_reader;

    logic        clk = 1'b0;
    logic        puc_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] cflow_log_ptr = 16'h0000;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rd_data = 16'h0000;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_last;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        log_clr;

    cflog_reader dut (
        .clk          (clk),
        .puc_n        (puc_n),
        .flush        (flush),
        .cflow_log_ptr(cflow_log_ptr),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .log_clr      (log_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] addr_q[$];
    int          checks = 0;
    int          failures = 0;
    int          words = 0;
    int          rds = 0;
    int          clrs = 0;
    int          busy_cycles = 0;
    int          ready_mode = 0;
    logic [15:0] last_addr = 16'h0000;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return 16'((a * 16'd40503) ^ 16'h5A3C);
    endfunction

    // Memory model: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_val(mem_addr);
        else           mem_rd_data <= 16'hDEAD;
    end

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1)      tx_ready = 1'b1;
        else if (ready_mode == 2) tx_ready = 1'($urandom_range(0, 1));
        else                      tx_ready = 1'b0;
    end

    logic        stall_prev = 1'b0;
    logic [15:0] data_prev = 16'h0000;
    logic        last_prev = 1'b0;
    exp_t        mon_e;
    logic [15:0] mon_a;

    always @(negedge clk) begin
        if (!puc_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== data_prev || tx_last !== last_prev) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             tx_valid, tx_data, tx_last, data_prev, last_prev);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                words++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_word: got unexpected data=%h last=%b, required no word", tx_data, tx_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (tx_data !== mon_e.data || tx_last !== mon_e.last) begin
                        failures++;
                        $display("FAIL tx_word: got data=%h last=%b, required data=%h last=%b",
                                 tx_data, tx_last, mon_e.data, mon_e.last);
                    end
                end
            end
            if (mem_rd_en === 1'b1) begin
                rds++;
                last_addr = mem_addr;
                checks++;
                if (addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_addr: got unexpected read at %h, required no read", mem_addr);
                end else begin
                    mon_a = addr_q.pop_front();
                    if (mem_addr !== mon_a) begin
                        failures++;
                        $display("FAIL rd_addr: got %h, required %h", mem_addr, mon_a);
                    end
                end
            end
            if (log_clr === 1'b1) clrs++;
            if (busy === 1'b1) busy_cycles++;
            stall_prev = (tx_valid === 1'b1) && (tx_ready !== 1'b1);
            data_prev  = tx_data;
            last_prev  = tx_last;
        end
    end

    task automatic do_flush(input logic [15:0] ptr, input logic [15:0] size);
        logic [15:0] c;
        c = (ptr > size) ? size : ptr;
        @(posedge clk);
        #1;
        cflow_log_ptr = ptr;
        flush = 1'b1;
        exp_q.push_back('{c, (c == 16'd0)});
        for (int i = 0; i < int'(c); i++) begin
            exp_q.push_back('{mem_val(16'(i)), (i == int'(c) - 1)});
            addr_q.push_back(16'(i));
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        cflow_log_ptr = ~ptr;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout: got busy=%b after %0d cycles, required busy=0", name, busy, n);
        end
    endtask

    task automatic check_drain(input string name, input int dw, input int dr, input int dc,
                               input int exp_w, input int exp_r);
        checks++;
        if (dw !== exp_w) begin
            failures++;
            $display("FAIL %s_words: got %0d, required %0d", name, dw, exp_w);
        end
        checks++;
        if (dr !== exp_r) begin
            failures++;
            $display("FAIL %s_reads: got %0d, required %0d", name, dr, exp_r);
        end
        checks++;
        if (dc !== 1) begin
            failures++;
            $display("FAIL %s_log_clr: got %0d pulses, required 1", name, dc);
        end
        checks++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL %s_leftover: got %0d words and %0d reads pending, required 0 and 0",
                     name, exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_reset();
        puc_n = 1'b0;
        #12;
        checks++;
        if ({mem_rd_en, tx_valid, tx_last, busy, log_clr} !== 5'b0 || tx_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: got rd=%b v=%b l=%b busy=%b clr=%b data=%h, required all 0",
                     mem_rd_en, tx_valid, tx_last, busy, log_clr, tx_data);
        end
        @(negedge clk);
        puc_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b valid=%b, required 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_basic();
        int w0, r0, c0, b0;
        ready_mode = 1;
        w0 = words; r0 = rds; c0 = clrs; b0 = busy_cycles;
        do_flush(16'd3, 16'h0100);
        wait_idle("basic", 200);
        check_drain("basic", words - w0, rds - r0, clrs - c0, 4, 3);
        checks++;
        if (busy_cycles - b0 !== 11) begin
            failures++;
            $display("FAIL basic_cycles: got %0d busy cycles, required 11", busy_cycles - b0);
        end
    endtask

    task automatic test_empty();
        int w0, r0, c0, b0;
        ready_mode = 1;
        w0 = words; r0 = rds; c0 = clrs; b0 = busy_cycles;
        do_flush(16'd0, 16'h0100);
        wait_idle("empty", 100);
        check_drain("empty", words - w0, rds - r0, clrs - c0, 1, 0);
        checks++;
        if (busy_cycles - b0 !== 2) begin
            failures++;
            $display("FAIL empty_cycles: got %0d busy cycles, required 2", busy_cycles - b0);
        end
    endtask

    task automatic test_clamp();
        int w0, r0, c0;
        ready_mode = 1;
        w0 = words; r0 = rds; c0 = clrs;
        do_flush(16'h0180, 16'h0100);
        wait_idle("clamp", 2000);
        check_drain("clamp", words - w0, rds - r0, clrs - c0, 257, 256);
        checks++;
        if (last_addr !== 16'h00FF) begin
            failures++;
            $display("FAIL clamp_last_addr: got %h, required 00ff", last_addr);
        end
    endtask

    task automatic test_back_to_back_stall();
        int w0, r0, c0;
        ready_mode = 2;
        w0 = words; r0 = rds; c0 = clrs;
        do_flush(16'd2, 16'h0100);
        repeat (2) @(posedge clk);
        #1;
        cflow_log_ptr = 16'd5;
        flush = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        flush = 1'b0;
        wait_idle("stall", 500);
        check_drain("stall", words - w0, rds - r0, clrs - c0, 3, 2);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_refire: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int w0, r0, c0, n;
        ready_mode = 1;
        w0 = words;
        do_flush(16'd4, 16'h0100);
        n = 0;
        @(negedge clk);
        while (!(words - w0 >= 2 && tx_valid === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (words - w0 < 2 || tx_valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reach: got words=%0d valid=%b, required 2 and 1", words - w0, tx_valid);
        end
        #2;
        puc_n = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, tx_valid, tx_last, busy, log_clr} !== 5'b0 || tx_data !== 16'h0) begin
            failures++;
            $display("FAIL midreset_async: got rd=%b v=%b l=%b busy=%b clr=%b data=%h, required all 0",
                     mem_rd_en, tx_valid, tx_last, busy, log_clr, tx_data);
        end
        exp_q.delete();
        addr_q.delete();
        c0 = clrs;
        repeat (3) @(negedge clk);
        puc_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (clrs !== c0) begin
            failures++;
            $display("FAIL midreset_no_clr: got %0d pulses, required 0", clrs - c0);
        end
        w0 = words; r0 = rds; c0 = clrs;
        do_flush(16'd2, 16'h0100);
        wait_idle("restart", 200);
        check_drain("restart", words - w0, rds - r0, clrs - c0, 3, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish within 200000");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_clamp();
        test_back_to_back_stall();
        test_reset_mid();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
